// File: rtl/texture_pkg.sv
// Shared texture-fetch types and widths used by the arbiter and its sub-blocks.
package texture_pkg;

  localparam int unsigned TEX_DIM      = 16;
  localparam int unsigned TEX_UV_W     = 4;
  localparam int unsigned PAL_IDX_W    = 8;
  localparam int unsigned RGB_W        = 4;
  // Upper bound on tex_id width; the struct field is zero-extended into this
  localparam int unsigned TEX_ID_MAX_W = 8;

  localparam logic [PAL_IDX_W-1:0] TRANSPARENT_IDX = 8'h00;

  typedef struct packed {
    logic [TEX_ID_MAX_W-1:0] tex_id;
    logic [TEX_UV_W-1:0]     u;
    logic [TEX_UV_W-1:0]     v;
  } texel_req_t;

endpackage

// File: rtl/texture_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// and the next pointer is the slot just after the winner.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    nxt_ptr = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        nxt_ptr       = (idx == N - 1) ? '0 : PW'(idx + 1);
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/texture_fetch_arbiter.sv
// Round-robin texel fetch arbiter in front of a shared texture ROM and palette.
// Optional TEX_TRANSPARENT_EN: palette index 0x00 is reported transparent with RGB forced to 0.
module texture_fetch_arbiter
  import texture_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 2,
  parameter  int unsigned TEX_ID_W = 3,
  localparam int unsigned PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned AW       = TEX_ID_W + 2 * TEX_UV_W
) (
  input  logic                         vga_clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*TEX_ID_W-1:0]  req_tex_id,
  input  logic [NUM_REQ*TEX_UV_W-1:0]  req_u,
  input  logic [NUM_REQ*TEX_UV_W-1:0]  req_v,
  output logic [AW-1:0]                rom_address,
  input  logic [PAL_IDX_W-1:0]         rom_q,
  output logic [PAL_IDX_W-1:0]         pal_index,
  input  logic [RGB_W-1:0]             pal_red,
  input  logic [RGB_W-1:0]             pal_green,
  input  logic [RGB_W-1:0]             pal_blue,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [RGB_W-1:0]             rsp_red,
  output logic [RGB_W-1:0]             rsp_green,
  output logic [RGB_W-1:0]             rsp_blue,
  output logic                         rsp_transparent
);

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d, nxt_ptr;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   tag_a_q, tag_a_d;
  logic                 vld_a_q, vld_a_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [3*RGB_W-1:0]   rgb_q, rgb_d;
  logic                 transp_q, transp_d;
  logic                 xfer;
  texel_req_t           sel;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .nxt_ptr (nxt_ptr)
  );

  // Grant is live from this cycle's inputs; reset and en both mask it.
  always_comb begin
    req_ready = (en && reset_n) ? gnt : '0;
    xfer      = |req_ready;
  end

  // Mux the granted requester's payload.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel.tex_id = TEX_ID_MAX_W'(req_tex_id[i*TEX_ID_W +: TEX_ID_W]);
        sel.u      = req_u[i*TEX_UV_W +: TEX_UV_W];
        sel.v      = req_v[i*TEX_UV_W +: TEX_UV_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = xfer ? nxt_ptr : rr_ptr_q;
    addr_d      = xfer ? AW'({sel.v, sel.u} | ((TEX_ID_MAX_W + 2*TEX_UV_W)'(sel.tex_id) << (2*TEX_UV_W)))
                       : addr_q;
    vld_a_d     = xfer;
    tag_a_d     = req_ready;
    rsp_valid_d = vld_a_q ? tag_a_q : '0;
    rgb_d       = rgb_q;
    transp_d    = transp_q;
    // rom_q/pal_* reflect stage-A's address, sampled by the ROM on the falling edge.
    if (vld_a_q) begin
`ifdef TEX_TRANSPARENT_EN
      transp_d = (rom_q == TRANSPARENT_IDX);
      rgb_d    = transp_d ? '0 : {pal_red, pal_green, pal_blue};
`else
      transp_d = 1'b0;
      rgb_d    = {pal_red, pal_green, pal_blue};
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      vld_a_q     <= 1'b0;
      tag_a_q     <= '0;
      rsp_valid_q <= '0;
      rgb_q       <= '0;
      transp_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      vld_a_q     <= vld_a_d;
      tag_a_q     <= tag_a_d;
      rsp_valid_q <= rsp_valid_d;
      rgb_q       <= rgb_d;
      transp_q    <= transp_d;
    end
  end

  assign pal_index       = rom_q;
  assign rom_address     = addr_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_red         = rgb_q[3*RGB_W-1:2*RGB_W];
  assign rsp_green       = rgb_q[2*RGB_W-1:RGB_W];
  assign rsp_blue        = rgb_q[RGB_W-1:0];
  assign rsp_transparent = transp_q;

endmodule

// File: tb/tb_texture_fetch_arbiter.sv
// Bench for texture_fetch_arbiter: directed table, corner sequences, and random
// traffic against a queue-free round-robin/ROM/palette reference model.
module tb_texture_fetch_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned TW = 3;
  localparam int unsigned AW = TW + 8;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid;
  logic [NR*TW-1:0]  req_tex_id;
  logic [NR*4-1:0]   req_u, req_v;
  logic [AW-1:0]     rom_address;
  logic [7:0]        rom_q, pal_index;
  logic [3:0]        pal_red, pal_green, pal_blue;
  logic [3:0]        rsp_red, rsp_green, rsp_blue;
  logic              rsp_transparent;

  logic [7:0]  rom_mem [2**AW];
  logic [11:0] pal_mem [256];

  texture_fetch_arbiter #(.NUM_REQ(NR), .TEX_ID_W(TW)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tex_id(req_tex_id), .req_u(req_u), .req_v(req_v),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid), .rsp_red(rsp_red), .rsp_green(rsp_green),
    .rsp_blue(rsp_blue), .rsp_transparent(rsp_transparent)
  );

  always #5 vga_clk = ~vga_clk;

  // External ROM on the falling edge, palette combinational.
  always @(negedge vga_clk) rom_q <= rom_mem[rom_address];
  assign {pal_red, pal_green, pal_blue} = pal_mem[pal_index];

  int total = 0;
  int bad   = 0;

  // Reference state
  int          rr;
  bit          pend;
  int          pend_tag;
  int          pend_addr;
  int          last_addr;
  logic [11:0] last_rgb;
  logic        last_tr;

  typedef struct {
    logic [1:0]  v;
    logic        en;
    logic [2:0]  t0, t1;
    logic [3:0]  v0, u0, v1, u1;
    logic [1:0]  xr;
    logic [31:0] xa;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic e,
                              input logic [2:0] t0, input logic [3:0] v0, input logic [3:0] u0,
                              input logic [2:0] t1, input logic [3:0] v1, input logic [3:0] u1,
                              input logic [1:0] xr, input logic [31:0] xa);
    vec_t r;
    r.v = v; r.en = e; r.t0 = t0; r.v0 = v0; r.u0 = u0;
    r.t1 = t1; r.v1 = v1; r.u1 = u1; r.xr = xr; r.xa = xa;
    return r;
  endfunction

  function automatic int winner(input logic [NR-1:0] v, input logic e);
    if (!e) return -1;
    for (int i = 0; i < NR; i++) begin
      int j = (rr + i) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    rr = 0; pend = 0; pend_tag = 0; pend_addr = 0;
    last_addr = 0; last_rgb = '0; last_tr = 1'b0;
  endtask

  // One clock of traffic: drive at negedge, check grant, then check edge results.
  task automatic run_vec(input vec_t x, input bit use_tbl);
    int w, addr, tex, uu, vv, idx;
    logic [NR-1:0] er, ev;
    logic [11:0]   ergb;
    logic          etr;
    @(negedge vga_clk);
    en = x.en; req_valid = x.v;
    req_tex_id = {x.t1, x.t0}; req_u = {x.u1, x.u0}; req_v = {x.v1, x.v0};
    #1;
    w  = winner(x.v, x.en);
    er = (w >= 0) ? NR'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (use_tbl) chk("tbl_ready", 32'(req_ready), 32'(x.xr));
    addr = 0;
    if (w >= 0) begin
      tex  = (w == 0) ? int'(x.t0) : int'(x.t1);
      vv   = (w == 0) ? int'(x.v0) : int'(x.v1);
      uu   = (w == 0) ? int'(x.u0) : int'(x.u1);
      addr = tex * 256 + vv * 16 + uu;
    end
    @(posedge vga_clk);
    #1;
    ev = '0;
    if (pend) begin
      ev   = NR'(1 << pend_tag);
      idx  = int'(rom_mem[pend_addr]);
      ergb = pal_mem[idx];
      etr  = 1'b0;
`ifdef TEX_TRANSPARENT_EN
      if (idx == 0) begin ergb = '0; etr = 1'b1; end
`endif
      last_rgb = ergb; last_tr = etr;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'(last_rgb));
    chk("rsp_transparent", 32'(rsp_transparent), 32'(last_tr));
    if (w >= 0) begin
      last_addr = addr;
      rr = (w + 1) % NR;
    end
    chk("rom_address", 32'(rom_address), 32'(last_addr));
    if (use_tbl && w >= 0) chk("tbl_addr", 32'(rom_address), x.xa);
    pend = (w >= 0); pend_tag = w; pend_addr = addr;
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)   pal_mem[i] = 12'($urandom);
    rom_mem[11'h235] = 8'h5A;
    rom_mem[11'h3AB] = 8'h00;
    pal_mem[0]       = 12'hABC;

    tbl[0]  = mk(2'b00, 1'b1, 3'd0, 4'd0,  4'd0,  3'd0, 4'd0, 4'd0,  2'b00, 32'h000);
    tbl[1]  = mk(2'b01, 1'b1, 3'd2, 4'd3,  4'd5,  3'd0, 4'd0, 4'd0,  2'b01, 32'h235);
    tbl[2]  = mk(2'b10, 1'b1, 3'd0, 4'd0,  4'd0,  3'd4, 4'd7, 4'd2,  2'b10, 32'h472);
    tbl[3]  = mk(2'b11, 1'b1, 3'd1, 4'd1,  4'd1,  3'd4, 4'd7, 4'd2,  2'b01, 32'h111);
    tbl[4]  = mk(2'b11, 1'b1, 3'd1, 4'd1,  4'd1,  3'd4, 4'd7, 4'd2,  2'b10, 32'h472);
    tbl[5]  = mk(2'b11, 1'b1, 3'd1, 4'd1,  4'd1,  3'd4, 4'd7, 4'd2,  2'b01, 32'h111);
    tbl[6]  = mk(2'b11, 1'b1, 3'd1, 4'd1,  4'd1,  3'd4, 4'd7, 4'd2,  2'b10, 32'h472);
    tbl[7]  = mk(2'b11, 1'b1, 3'd1, 4'd1,  4'd1,  3'd4, 4'd7, 4'd2,  2'b01, 32'h111);
    tbl[8]  = mk(2'b11, 1'b1, 3'd1, 4'd1,  4'd1,  3'd4, 4'd7, 4'd2,  2'b10, 32'h472);
    tbl[9]  = mk(2'b11, 1'b1, 3'd6, 4'd14, 4'd15, 3'd4, 4'd7, 4'd3,  2'b01, 32'h6EF);
    tbl[10] = mk(2'b11, 1'b1, 3'd6, 4'd14, 4'd15, 3'd4, 4'd7, 4'd10, 2'b10, 32'h47A);
    tbl[11] = mk(2'b11, 1'b0, 3'd6, 4'd14, 4'd15, 3'd4, 4'd7, 4'd10, 2'b00, 32'h000);
    tbl[12] = mk(2'b00, 1'b1, 3'd0, 4'd0,  4'd0,  3'd0, 4'd0, 4'd0,  2'b00, 32'h000);
    tbl[13] = mk(2'b10, 1'b1, 3'd0, 4'd0,  4'd0,  3'd5, 4'd5, 4'd5,  2'b10, 32'h555);

    // Reset values, with requests pending to show ready stays low in reset.
    reset_n = 1'b0; en = 1'b1; req_valid = 2'b11;
    req_tex_id = '0; req_u = '0; req_v = '0;
    #12;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rom_address", 32'(rom_address), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h0);
    chk("reset_transparent", 32'(rsp_transparent), 32'h0);
    req_valid = '0;
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();

    for (int i = 0; i < 14; i++) run_vec(tbl[i], 1'b1);

    // Reset pulse between acceptance and response drops the response.
    run_vec(mk(2'b10, 1'b1, 3'd0, 4'd0, 4'd0, 3'd7, 4'd9, 4'd9, 2'b10, 32'h799), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_ready", 32'(req_ready), 32'h0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = '0;
    @(posedge vga_clk);
    #1 chk("midreset_rsp_held", 32'(rsp_valid), 32'h0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
    run_vec(mk(2'b11, 1'b1, 3'd2, 4'd3, 4'd5, 3'd4, 4'd7, 4'd2, 2'b01, 32'h235), 1'b1);

    // Palette index 0 texel.
    run_vec(mk(2'b10, 1'b1, 3'd0, 4'd0, 4'd0, 3'd3, 4'd10, 4'd11, 2'b10, 32'h3AB), 1'b1);
    run_vec(mk(2'b00, 1'b1, 3'd0, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 2'b00, 32'h0), 1'b1);
`ifdef TEX_TRANSPARENT_EN
    chk("idx0_transparent", 32'(rsp_transparent), 32'h1);
    chk("idx0_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h000);
`else
    chk("idx0_transparent", 32'(rsp_transparent), 32'h0);
    chk("idx0_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'hABC);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rv = mk(2'($urandom), ($urandom_range(0, 7) != 0),
              3'($urandom), 4'($urandom), 4'($urandom),
              3'($urandom), 4'($urandom), 4'($urandom), 2'b00, 32'h0);
      run_vec(rv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/texture_fetch_arbiter.md
# texture_fetch_arbiter

Shares one texture ROM and its palette between several texel requesters, e.g. the wall/block rasteriser and the arrow sprite renderer. The ROM is clocked on the falling edge of `vga_clk`. Each cycle the block grants one requester by round-robin and forms the ROM address from `{tex_id, v, u}`. It returns the palette-resolved 4-bit RGB to that requester one cycle later, tagged with a one-hot `rsp_valid`. It sits between the render pipelines and the `*_rom` / `*_palette` instances.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, ≥1.
- `TEX_ID_W`, 3: texture-select width; ROM holds 2^TEX_ID_W textures of 16×16 texels.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `vga_clk`  in  1  pixel clock; the only clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `en`  in  1  grant enable; low blocks new grants, in-flight work completes.
- `req_valid`  in  NUM_REQ  per-requester fetch request.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready.
- `req_tex_id`  in  NUM_REQ×TEX_ID_W  texture select per requester.
- `req_u`, `req_v`  in  NUM_REQ×4 each  texel column/row.
- `rom_address`  out  TEX_ID_W+8  registered ROM address.
- `rom_q`  in  8  palette index from the ROM, valid before the next rising edge.
- `pal_index`  out  8  equals `rom_q` (combinational pass-through).
- `pal_red`, `pal_green`, `pal_blue`  in  4 each  combinational palette output.
- `rsp_valid`  out  NUM_REQ  one-hot response strobe, 1 cycle wide.
- `rsp_red`, `rsp_green`, `rsp_blue`  out  4 each  registered texel colour.
- `rsp_transparent`  out  1  texel is transparent (see Configuration).

## Operation
- Arbitration: round-robin pointer `rr_ptr`.
  - Search order: rr_ptr, rr_ptr+1, … mod NUM_REQ; the first requester with `req_valid` set wins.
  - `req_ready[w]` = `en` & `req_valid[w]`. This is combinational from the current-cycle inputs; all other ready bits are 0.
  - On a transfer, `rr_ptr` ← (w+1) mod NUM_REQ. With no transfer, `rr_ptr` holds.
- Address: `rom_address` ← `{req_tex_id[w], req_v[w], req_u[w]}` = tex_id·256 + v·16 + u. Pure concatenation; no range check.
- Pipeline stage A (posedge k): latch the address and the one-hot `tag_a` = 1<<w; `vld_a` = transfer.
- Stage B (posedge k+1), when `vld_a`: `rsp_valid` ← `tag_a`, and `rsp_*` ← `pal_*`. Otherwise `rsp_valid` ← 0 and `rsp_*` holds.
- Throughput: one fetch per cycle total. There is no response back-pressure; requesters must sink responses.
- Requesters keep valid and payload stable until accepted. A payload change while not ready is legal and is the value sampled at acceptance.
- `en` low: no grants. A stage-A entry already captured still produces its response.

## Timing
- Latency: acceptance edge k → `rsp_valid` high on edge k+1 (1 cycle).
- The ROM samples `rom_address` at the falling edge k+½. `rom_q` → palette → `rsp_*` must settle within the half cycle before edge k+1.
- Back-to-back grants give a response every cycle, with the tag following the grant order.
- Reset values: `rom_address`=0, `rsp_valid`=0, `rsp_*`=0, `rsp_transparent`=0, `rr_ptr`=0, `vld_a`=0.
- `req_ready`=0 while `reset_n` is low.
- Reset asserted mid-fetch: the in-flight response is dropped and no `rsp_valid` is produced after release.
- First cycle after reset: requester 0 has top priority.
- NUM_REQ=1: `rr_ptr` is constant 0 and the grant follows `req_valid[0]` & `en`.

## Configuration
- `TEX_TRANSPARENT_EN` defined:
  - Stage B sets `rsp_transparent` ← (`rom_q` == 8'h00) when `vld_a`.
  - `rsp_red`, `rsp_green`, `rsp_blue` are forced to 0 for those texels.
- Undefined: `rsp_transparent` is tied 0 and palette entry 0 is an ordinary colour.

## Structure
- Shared package `texture_pkg`:
  - `TEX_DIM`=16, `TEX_UV_W`=4, `PAL_IDX_W`=8, `RGB_W`=4.
  - `texel_req_t` struct {tex_id, u, v}.
  - `TRANSPARENT_IDX`=8'h00.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`; outputs one-hot `gnt` and the next pointer; combinational.
- The block instantiates `rr_arbiter` and holds both pipeline stages itself. The ROM and palette stay external.

## Test plan
- Reset, then `req_valid`=2'b01, tex_id=2, u=5, v=3 → `req_ready`=01, `rom_address`=0x235, and on the next edge `rsp_valid`=01 with `rsp_*` equal to palette[ROM[0x235]].
- Both requesters held valid for 6 cycles → grants 0,1,0,1,0,1; `rsp_valid` follows one cycle behind, and tags match the addresses issued.
- `en` dropped on the cycle after a grant → that response still appears; no further `req_ready` until `en` rises.
- `reset_n` pulsed low between acceptance and response → `rsp_valid` stays 0; after release requester 0 wins a simultaneous request.
- With `TEX_TRANSPARENT_EN`, a texel whose ROM index is 0x00 → `rsp_transparent`=1 and RGB=0. Without the macro → `rsp_transparent`=0 and RGB=palette[0].
- Requester 1 changes u while blocked by requester 0 → the granted address reflects the payload at the acceptance cycle.
